dmem_sram_bridge: RTL and testbench
===================================

Name: dmem_sram_bridge

Overview:
- Load/store bridge between the core's memory stage and the 64-bit byte-strobed data SRAM (1-cycle registered read, 14-bit doubleword index).
- Accepts one request per cycle over a valid/ready handshake and drives SRAM enable, byte strobes, index and lane-shifted write data.
- Returns loads extracted and sign/zero-extended to 64 bits, plus a misalignment error flag.
- Buffers the response when the core stalls, because SRAM read data is only valid for one cycle.

Parameters:
- IDX_W, 14: SRAM doubleword index width; ram_addr = req_addr[IDX_W+2:3].
- AW, 64: request address width.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  bridge accepts request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double.
- req_unsigned  in  1  zero-extend load (ignored for double and for stores).
- req_addr  in  AW  byte address.
- req_wdata  in  64  store data, right-aligned.
- resp_valid  out  1  response present.
- resp_ready  in  1  core takes response.
- resp_rdata  out  64  load result; 0 for stores and errors.
- resp_err  out  1  misaligned access.
- ram_en  out  1  SRAM enable.
- ram_we  out  8  SRAM byte strobes.
- ram_addr  out  IDX_W  SRAM index.
- ram_wdata  out  64  lane-shifted store data.
- ram_rdata  in  64  SRAM read data, valid the cycle after the address edge.

Behaviour:
- Accept: accept = req_valid & req_ready.
- SRAM drive: combinational from req_* on the accept cycle only.
  - ram_en = accept & ~mis.
  - ram_we = strobe on a store, else 0.
  - In all other cycles ram_en = 0 and ram_we = 0. ram_addr and ram_wdata are don't-care.
- Misalignment: off = req_addr[2:0]. mis = (size 1 & off[0]) | (size 2 & |off[1:0]) | (size 3 & |off).
- Strobes: byte 8'h01<<off; half 8'h03<<off; word 8'h0F<<off; double 8'hFF.
- Write data: ram_wdata = req_wdata << (8*off). Address bits above IDX_W+2 are ignored, so the index wraps.
- Captured at accept: off, size, unsigned, we, mis.
- FSM states: IDLE, RESP, HOLD.
  - IDLE:
    - resp_valid = 0; req_ready = 1.
    - accept -> RESP.
  - RESP:
    - resp_valid = 1.
    - resp_rdata = formatted ram_rdata, or 0 if we or mis. resp_err = captured mis.
    - req_ready = resp_ready.
    - resp_ready & accept -> RESP (new capture; throughput 1/cycle).
    - resp_ready & ~accept -> IDLE.
    - ~resp_ready -> HOLD, with the formatted rdata and err latched into the hold register.
  - HOLD:
    - resp_valid = 1; outputs come from the hold register; req_ready = 0.
    - resp_ready -> IDLE.
- Load formatting: lane = ram_rdata >> (8*off), then take the low 8/16/32/64 bits. Sign-extend from bit 7/15/31 unless unsigned.
- Store completion: the store is complete in SRAM at the accept edge. Its response carries rdata 0, err 0.
- Misaligned request: no SRAM access at all. The response carries err 1 and rdata 0.
- Reset:
  - State = IDLE; hold register = 0; captured fields = 0.
  - All outputs 0 except req_ready = 1.
  - Reset mid-transaction drops the pending response; a store already issued stays written.
- Ordering: responses return strictly in request order. At most one response is outstanding.
- resp_ready while resp_valid = 0 is ignored.
- req_* inputs must be stable only on the accept cycle.

Test Plan:
- Store double 0x1122334455667788 at 0x100, then load double 0x100.
  - Store cycle: ram_we = FF, ram_addr = 0x20.
  - Load response on the next cycle after accept: 0x1122334455667788, err 0.
- Load byte at 0x107, signed, then unsigned.
  - ram_rdata byte 7 = 0x80.
  - Signed gives 0xFFFFFFFFFFFFFF80; unsigned gives 0x80.
- Store half 0xBEEF at 0x10A.
  - ram_we = 8'h0C; ram_wdata[31:16] = 0xBEEF.
- Load word at 0x102 (misaligned).
  - ram_en stays 0; response err 1, rdata 0.
- Back-to-back loads at 0x0 and 0x8 with resp_ready held high.
  - Two accepts in consecutive cycles; responses on consecutive cycles.
- Load with resp_ready = 0 for 3 cycles while ram_rdata changes.
  - Response stays in HOLD with the original data; req_ready = 0 until resp_ready = 1.
- Assert rst while in HOLD.
  - resp_valid drops to 0 immediately (asynchronously); state IDLE; req_ready = 1.

Source files
------------

// File: rtl/dmem_sram_bridge_if.sv
// Core-side load/store handshake and SRAM port bundle for dmem_sram_bridge.
// The bridge uses the slave modport; the core/SRAM environment uses master.
interface dmem_sram_bridge_if #(
  parameter int IDX_W = 14,
  parameter int AW    = 64
);
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [1:0]       req_size;
  logic             req_unsigned;
  logic [AW-1:0]    req_addr;
  logic [63:0]      req_wdata;
  logic             resp_valid;
  logic             resp_ready;
  logic [63:0]      resp_rdata;
  logic             resp_err;
  logic             ram_en;
  logic [7:0]       ram_we;
  logic [IDX_W-1:0] ram_addr;
  logic [63:0]      ram_wdata;
  logic [63:0]      ram_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  resp_ready, ram_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output resp_ready, ram_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/dmem_sram_bridge.sv
// Load/store bridge from the memory stage to a 64-bit byte-strobed SRAM with a
// one-cycle registered read; formats loads and buffers a stalled response.
module dmem_sram_bridge #(
  parameter int IDX_W = 14,
  parameter int AW    = 64
) (
  input  logic              clk,
  input  logic              rst,
  dmem_sram_bridge_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RESP, HOLD} state_t;

  state_t      state, state_nxt;
  logic [2:0]  off;
  logic        mis;
  logic [7:0]  strobe;
  logic        req_ready_c;
  logic        accept;
  logic        drive;
  logic        hold_load;

  logic [2:0]  cap_off;
  logic [1:0]  cap_size;
  logic        cap_unsigned;
  logic        cap_we;
  logic        cap_mis;
  logic [63:0] hold_rdata;
  logic        hold_err;

  logic [63:0] lane;
  logic [63:0] fmt_rdata;
  logic [63:0] resp_data_live;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^bus.req_addr[AW-1:IDX_W+3];

  assign off = bus.req_addr[2:0];

  always_comb begin
    mis    = 1'b0;
    strobe = 8'h00;
    case (bus.req_size)
      2'd0: begin
        mis    = 1'b0;
        strobe = 8'h01 << off;
      end
      2'd1: begin
        mis    = off[0];
        strobe = 8'h03 << off;
      end
      2'd2: begin
        mis    = |off[1:0];
        strobe = 8'h0F << off;
      end
      default: begin
        mis    = |off;
        strobe = 8'hFF;
      end
    endcase
  end

  // Ready depends only on state and resp_ready, keeping accept free of loops.
  assign req_ready_c = (state == IDLE) || ((state == RESP) && bus.resp_ready);
  assign accept      = bus.req_valid && req_ready_c;
  assign drive       = accept && !mis && !rst;

  assign bus.req_ready = req_ready_c;
  assign bus.ram_en    = drive;
  assign bus.ram_we    = (drive && bus.req_we) ? strobe : 8'h00;
  assign bus.ram_addr  = drive ? bus.req_addr[IDX_W+2:3] : '0;
  assign bus.ram_wdata = drive ? (bus.req_wdata << {off, 3'b000}) : 64'h0;

  always_comb begin
    lane      = bus.ram_rdata >> {cap_off, 3'b000};
    fmt_rdata = lane;
    case (cap_size)
      2'd0:    fmt_rdata = {{56{~cap_unsigned & lane[7]}},  lane[7:0]};
      2'd1:    fmt_rdata = {{48{~cap_unsigned & lane[15]}}, lane[15:0]};
      2'd2:    fmt_rdata = {{32{~cap_unsigned & lane[31]}}, lane[31:0]};
      default: fmt_rdata = lane;
    endcase
  end

  assign resp_data_live = (cap_we || cap_mis) ? 64'h0 : fmt_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    hold_load      = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = 64'h0;
    bus.resp_err   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_rdata = resp_data_live;
        bus.resp_err   = cap_mis;
        if (bus.resp_ready) begin
          state_nxt = accept ? RESP : IDLE;
        end else begin
          state_nxt = HOLD;
          hold_load = 1'b1;
        end
      end
      HOLD: begin
        bus.resp_valid = 1'b1;
        bus.resp_rdata = hold_rdata;
        bus.resp_err   = hold_err;
        if (bus.resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_off      <= 3'd0;
      cap_size     <= 2'd0;
      cap_unsigned <= 1'b0;
      cap_we       <= 1'b0;
      cap_mis      <= 1'b0;
    end else if (accept) begin
      cap_off      <= off;
      cap_size     <= bus.req_size;
      cap_unsigned <= bus.req_unsigned;
      cap_we       <= bus.req_we;
      cap_mis      <= mis;
    end
  end

  // SRAM read data lasts one cycle, so a stalled response is frozen here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_rdata <= 64'h0;
      hold_err   <= 1'b0;
    end else if (hold_load) begin
      hold_rdata <= resp_data_live;
      hold_err   <= cap_mis;
    end
  end

endmodule

// File: tb/tb_dmem_sram_bridge.sv
// Self-checking bench for dmem_sram_bridge: directed scenarios plus random
// traffic against a byte-addressed reference memory and a response model.
module tb_dmem_sram_bridge;

  logic clk;
  logic rst;

  dmem_sram_bridge_if #(.IDX_W(14), .AW(64)) bus ();

  dmem_sram_bridge #(.IDX_W(14), .AW(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int assert_count = 0;
  int fail_count   = 0;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [63:0] initWord(input logic [31:0] i);
    return {i[15:0] ^ 16'hA5C3, ~i[15:0], i[15:0] * 16'd7, i[15:0] + 16'h1234};
  endfunction

  // SRAM environment: registered read, garbage on the data bus otherwise.
  logic [63:0] sram [0:16383];
  bit          sram_init = 1'b0;

  always @(posedge clk) begin
    if (!sram_init) begin
      for (int i = 0; i < 16384; i++) sram[i] <= initWord(32'(i));
      sram_init <= 1'b1;
    end
    if (bus.ram_en) begin
      for (int b = 0; b < 8; b++)
        if (bus.ram_we[b]) sram[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
    end
    if (bus.ram_en && bus.ram_we == 8'h00) bus.ram_rdata <= sram[bus.ram_addr];
    else bus.ram_rdata <= {$urandom, $urandom};
  end

  // Reference model: byte memory plus one outstanding response.
  logic [7:0]  ref_mem [int unsigned];
  bit          pending = 1'b0;
  bit          held    = 1'b0;
  logic [63:0] exp_data = 64'h0;
  logic        exp_err  = 1'b0;

  function automatic logic [7:0] refByte(input int unsigned k);
    logic [63:0] w;
    if (ref_mem.exists(k)) return ref_mem[k];
    w = initWord(32'(k >> 3));
    return w[8*(k % 8) +: 8];
  endfunction

  task automatic applyStimulus(input bit v, input bit we, input logic [1:0] sz,
                               input bit uns, input logic [63:0] a,
                               input logic [63:0] wd, input bit rr);
    int          nb;
    int          offs;
    int unsigned base;
    bit          mis;
    bit          exp_ready;
    bit          acc;
    logic [7:0]  mask;
    logic [63:0] val;
    @(negedge clk);
    bus.req_valid    = v;
    bus.req_we       = we;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    bus.resp_ready   = rr;
    #1;
    nb   = 1 << sz;
    offs = int'(a[2:0]);
    base = int'(a[16:0]);
    mis  = (offs % nb) != 0;
    mask = 8'h00;
    for (int i = 0; i < nb; i++) if (offs + i < 8) mask = mask | 8'(1 << (offs + i));

    exp_ready = !pending || (rr && !held);
    checkOutput("req_ready", 64'(bus.req_ready), 64'(exp_ready));
    checkOutput("resp_valid", 64'(bus.resp_valid), 64'(pending));
    if (pending) begin
      checkOutput("resp_rdata", bus.resp_rdata, exp_data);
      checkOutput("resp_err", 64'(bus.resp_err), 64'(exp_err));
    end
    acc = v && exp_ready;
    checkOutput("ram_en", 64'(bus.ram_en), 64'(acc && !mis));
    checkOutput("ram_we", 64'(bus.ram_we), (acc && !mis && we) ? 64'(mask) : 64'h0);
    if (acc && !mis) begin
      checkOutput("ram_addr", 64'(bus.ram_addr), 64'(a[16:3]));
      if (we) checkOutput("ram_wdata", bus.ram_wdata, wd << (8 * offs));
    end

    if (pending && rr) pending = 1'b0;
    else if (pending) held = 1'b1;
    if (acc) begin
      pending = 1'b1;
      held    = 1'b0;
      if (mis) begin
        exp_data = 64'h0;
        exp_err  = 1'b1;
      end else if (we) begin
        for (int i = 0; i < nb; i++) ref_mem[(base + i) % 131072] = wd[8*i +: 8];
        exp_data = 64'h0;
        exp_err  = 1'b0;
      end else begin
        val = 64'h0;
        for (int i = 0; i < nb; i++) val = val | (64'(refByte((base + i) % 131072)) << (8 * i));
        if (!uns && sz != 2'd3 && val[8*nb-1]) val = val | (~64'h0 << (8 * nb));
        exp_data = val;
        exp_err  = 1'b0;
      end
    end
  endtask

  task automatic idleCycle(input bit rr);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, rr);
  endtask

  initial begin
    logic [63:0] a;
    logic [1:0]  sz;
    int          nb;
    rst              = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 64'h0;
    bus.req_wdata    = 64'h0;
    bus.resp_ready   = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_req_ready", 64'(bus.req_ready), 64'h1);
    checkOutput("rst_resp_valid", 64'(bus.resp_valid), 64'h0);
    checkOutput("rst_resp_rdata", bus.resp_rdata, 64'h0);
    checkOutput("rst_resp_err", 64'(bus.resp_err), 64'h0);
    checkOutput("rst_ram_en", 64'(bus.ram_en), 64'h0);
    checkOutput("rst_ram_we", 64'(bus.ram_we), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] store/load double");
    applyStimulus(1'b1, 1'b1, 2'd3, 1'b0, 64'h100, 64'h1122334455667788, 1'b1);
    applyStimulus(1'b1, 1'b0, 2'd3, 1'b0, 64'h100, 64'h0, 1'b1);
    idleCycle(1'b1);
    checkOutput("dbl_const", exp_data, 64'h1122334455667788);

    $display("[TB] signed/unsigned byte");
    applyStimulus(1'b1, 1'b1, 2'd0, 1'b0, 64'h107, 64'h80, 1'b1);
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 64'h107, 64'h0, 1'b1);
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b1, 64'h107, 64'h0, 1'b1);
    idleCycle(1'b1);

    $display("[TB] half store, misaligned word, back-to-back loads");
    applyStimulus(1'b1, 1'b1, 2'd1, 1'b0, 64'h10A, 64'hBEEF, 1'b1);
    applyStimulus(1'b1, 1'b0, 2'd2, 1'b0, 64'h102, 64'h0, 1'b1);
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 64'h0, 64'h0, 1'b1);
    applyStimulus(1'b1, 1'b0, 2'd3, 1'b0, 64'h8, 64'h0, 1'b1);
    idleCycle(1'b1);

    $display("[TB] stalled response");
    applyStimulus(1'b1, 1'b0, 2'd2, 1'b0, 64'h104, 64'h0, 1'b0);
    idleCycle(1'b0);
    idleCycle(1'b0);
    idleCycle(1'b0);
    applyStimulus(1'b1, 1'b0, 2'd3, 1'b0, 64'h100, 64'h0, 1'b1);
    idleCycle(1'b1);

    $display("[TB] reset while holding");
    applyStimulus(1'b1, 1'b0, 2'd3, 1'b0, 64'h100, 64'h0, 1'b0);
    idleCycle(1'b0);
    idleCycle(1'b0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("hold_rst_resp_valid", 64'(bus.resp_valid), 64'h0);
    checkOutput("hold_rst_req_ready", 64'(bus.req_ready), 64'h1);
    pending = 1'b0;
    held    = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 2'd3, 1'b0, 64'h100, 64'h0, 1'b1);
    idleCycle(1'b1);

    $display("[TB] random traffic");
    for (int n = 0; n < 600; n++) begin
      sz = 2'($urandom_range(0, 3));
      nb = 1 << sz;
      a  = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0) a[16:0] = 17'($urandom_range(0, 255));
      if ($urandom_range(0, 4) != 0) a = a & ~64'(nb - 1);
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, sz,
                    1'($urandom_range(0, 1)), a, {$urandom, $urandom},
                    $urandom_range(0, 3) != 0);
    end
    idleCycle(1'b1);
    idleCycle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
